// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and widths for the data-memory responder
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int DW_BYTES  = 8;
   localparam int DW_BITS   = 64;
   localparam int WAITCNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - DEPTH x 64-bit storage, reset-cleared, byte-masked write port
// Byte strobes honoured only when DMEM_BYTE_STRB_EN is defined; otherwise every write is full-width.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                we,
   input  logic [IDX_W-1:0]    idx,
   input  logic [DW_BITS-1:0]  wdata,
   input  logic [DW_BYTES-1:0] wstrb,
   output logic [DW_BITS-1:0]  rdata
);

   logic [DW_BITS-1:0]  mem [DEPTH];
   logic [DW_BYTES-1:0] byte_mask;

`ifdef DMEM_BYTE_STRB_EN
   assign byte_mask = wstrb;
`else
   assign byte_mask = wstrb | {DW_BYTES{1'b1}};
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         for (int b = 0; b < DW_BYTES; b++) begin
            if (byte_mask[b]) begin
               mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle load/store target with programmable wait states
// Optional byte-strobe stores via DMEM_BYTE_STRB_EN (handled inside dmem_array).
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2,
   parameter int ADDR_W      = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DW_BITS-1:0]  req_wdata,
   input  logic [DW_BYTES-1:0] req_wstrb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DW_BITS-1:0]  rsp_rdata,
   output logic                rsp_err,
   output logic                busy
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam bit NO_WAIT = (WAIT_CYCLES == 0);
   localparam logic [WAITCNT_W-1:0] WAIT_LOAD =
      (WAIT_CYCLES == 0) ? '0 : WAITCNT_W'(WAIT_CYCLES - 1);

   state_t state, state_next;
   logic [WAITCNT_W-1:0] wait_cnt, wait_cnt_next;

   logic                cap_write;
   logic [ADDR_W-1:0]   cap_addr;
   logic [DW_BITS-1:0]  cap_wdata;
   logic [DW_BYTES-1:0] cap_wstrb;

   logic                capture;
   logic                access;
   logic                rsp_clear;

   logic                acc_write;
   logic [ADDR_W-1:0]   acc_addr;
   logic [DW_BITS-1:0]  acc_wdata;
   logic [DW_BYTES-1:0] acc_wstrb;
   logic [IDX_W-1:0]    acc_idx;
   logic                acc_err;
   logic                mem_we;
   logic [DW_BITS-1:0]  mem_rdata;

   // With zero wait states the access lands on the accept edge, so it must come from the pins.
   always_comb begin
      acc_write = cap_write;
      acc_addr  = cap_addr;
      acc_wdata = cap_wdata;
      acc_wstrb = cap_wstrb;
      if (state == IDLE) begin
         acc_write = req_write;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
         acc_wstrb = req_wstrb;
      end
   end

   assign acc_idx = acc_addr[3 +: IDX_W];
   assign acc_err = (acc_addr[2:0] != 3'b000) || (|acc_addr[ADDR_W-1:3+IDX_W]);
   assign mem_we  = access && acc_write && !acc_err;

   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      capture       = 1'b0;
      access        = 1'b0;
      rsp_clear     = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               capture = 1'b1;
               if (NO_WAIT) begin
                  access     = 1'b1;
                  state_next = RESP;
               end else begin
                  wait_cnt_next = WAIT_LOAD;
                  state_next    = WAIT;
               end
            end
         end
         WAIT: begin
            if (wait_cnt == '0) begin
               access     = 1'b1;
               state_next = RESP;
            end else begin
               wait_cnt_next = wait_cnt - WAITCNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_clear  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         cap_write <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         cap_wstrb <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
         if (capture) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_wstrb <= req_wstrb;
         end
         if (access) begin
            rsp_err   <= acc_err;
            rsp_rdata <= (acc_err || acc_write) ? '0 : mem_rdata;
         end else if (rsp_clear) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
         end
      end
   end

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

   dmem_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk   (clk),
      .reset (reset),
      .we    (mem_we),
      .idx   (acc_idx),
      .wdata (acc_wdata),
      .wstrb (acc_wstrb),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder against a byte-level memory model
module tb_dmem_responder;

   localparam int DEPTH       = 256;
   localparam int WAIT_CYCLES = 2;
   localparam int ADDR_W      = 64;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [63:0]       req_wdata;
   logic [7:0]        req_wstrb;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [63:0]       rsp_rdata;
   logic              rsp_err;
   logic              busy;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          acc_cyc;
   } exp_t;

   exp_t        exp_q[$];
   logic [63:0] model_mem [DEPTH];
   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;

   dmem_responder #(
      .DEPTH       (DEPTH),
      .WAIT_CYCLES (WAIT_CYCLES),
      .ADDR_W      (ADDR_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%016h required=0x%016h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   function automatic void model_clear();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 64'd0;
   endfunction

   // Memory as an array of doublewords; stores merge byte by byte.
   function automatic void model_access(input logic wr, input logic [63:0] addr,
                                        input logic [63:0] wd, input logic [7:0] ws,
                                        output logic [63:0] rd, output logic err);
      int idx;
      bit en;
      err = ((addr % 64'd8) != 64'd0) || ((addr / 64'd8) >= 64'(DEPTH));
      rd  = 64'd0;
      if (!err) begin
         idx = int'(addr / 64'd8);
         if (wr) begin
            for (int b = 0; b < 8; b++) begin
`ifdef DMEM_BYTE_STRB_EN
               en = ws[b];
`else
               en = 1'b1;
`endif
               if (en) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
            end
         end else begin
            rd = model_mem[idx];
         end
      end
   endfunction

   initial begin
      logic        prev_valid;
      logic [63:0] hold_rdata;
      logic        hold_err;
      exp_t        e;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_valid = 1'b0;
         end else begin
            if (rsp_valid) begin
               if (!prev_valid) begin
                  hold_rdata = rsp_rdata;
                  hold_err   = rsp_err;
                  if (exp_q.size() == 0) fail_now("spurious_response");
                  else check64("latency", 64'(cyc - exp_q[0].acc_cyc), 64'(WAIT_CYCLES + 1));
               end else begin
                  check64("rsp_rdata_stable", rsp_rdata, hold_rdata);
                  check64("rsp_err_stable", 64'(rsp_err), 64'(hold_err));
               end
               check64("req_ready_in_resp", 64'(req_ready), 64'd0);
               check64("busy_in_resp", 64'(busy), 64'd1);
               if (rsp_ready && exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check64("rsp_rdata", rsp_rdata, e.rdata);
                  check64("rsp_err", 64'(rsp_err), 64'(e.err));
               end
            end
            prev_valid = rsp_valid & ~rsp_ready;
         end
      end
   end

   task automatic wait_ready(output bit ok);
      int n = 0;
      while (!req_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      ok = req_ready;
      if (!ok) fail_now("req_ready_timeout");
   endtask

   task automatic do_req(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                         input logic [7:0] ws, input int stall, input bit pulse);
      exp_t e;
      bit   ok;
      int   n;
      wait_ready(ok);
      if (!ok) return;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      req_wstrb = ws;
      model_access(wr, addr, wd, ws, e.rdata, e.err);
      e.acc_cyc = cyc;
      exp_q.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom};
      req_wstrb = 8'($urandom);
      for (int i = 0; i < stall; i++) begin
         if (pulse) req_valid = 1'($urandom_range(0, 1));
         rsp_ready = !rsp_valid && ($urandom_range(0, 1) == 1);
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(rsp_valid && rsp_ready) && n < 200);
      if (!rsp_valid) begin
         fail_now("rsp_timeout");
         exp_q.delete();
      end
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      model_clear();
      exp_q.delete();
   endtask

   initial begin
      bit          ok;
      logic [63:0] a;
      int          sel;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_wstrb = '0;
      rsp_ready = 1'b0;
      reset     = 1'b0;
      apply_reset();

      check64("reset_req_ready", 64'(req_ready), 64'd1);
      check64("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check64("reset_busy", 64'(busy), 64'd0);
      check64("reset_rsp_rdata", rsp_rdata, 64'd0);
      check64("reset_rsp_err", 64'(rsp_err), 64'd0);

      do_req(1'b0, 64'h10, 64'd0, 8'h00, 0, 1'b0);
      do_req(1'b1, 64'h18, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1, 1'b0);
      do_req(1'b0, 64'h18, 64'd0, 8'h00, 0, 1'b0);
      do_req(1'b1, 64'h08, 64'h01234567_89ABCDEF, 8'hFF, 0, 1'b0);
      do_req(1'b0, 64'h0C, 64'd0, 8'h00, 0, 1'b0);
      do_req(1'b0, 64'h800, 64'd0, 8'h00, 0, 1'b0);
      do_req(1'b1, 64'h800, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 1'b0);
      do_req(1'b0, 64'h08, 64'd0, 8'h00, 0, 1'b0);
      do_req(1'b1, 64'(8 * (DEPTH - 1)), 64'h0BAD_F00D_1234_5678, 8'hFF, 0, 1'b0);
      do_req(1'b0, 64'(8 * (DEPTH - 1)), 64'd0, 8'h00, 0, 1'b0);
      do_req(1'b0, 64'h0, 64'd0, 8'h00, 0, 1'b0);
      do_req(1'b0, 64'h18, 64'd0, 8'h00, 10, 1'b1);

      // Reset lands on the edge that would commit the store.
      wait_ready(ok);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 64'h20;
      req_wdata = 64'h5555_6666_7777_8888;
      req_wstrb = 8'hFF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_clear();
      check64("post_reset_busy", 64'(busy), 64'd0);
      check64("post_reset_req_ready", 64'(req_ready), 64'd1);
      check64("post_reset_rsp_valid", 64'(rsp_valid), 64'd0);
      do_req(1'b0, 64'h20, 64'd0, 8'h00, 0, 1'b0);
      do_req(1'b0, 64'h18, 64'd0, 8'h00, 0, 1'b0);

      do_req(1'b1, 64'h40, 64'h11223344_55667788, 8'hFF, 0, 1'b0);
      do_req(1'b1, 64'h40, 64'hAAAAAAAA_AAAAAAAA, 8'h0F, 0, 1'b0);
      do_req(1'b0, 64'h40, 64'd0, 8'h00, 0, 1'b0);
      do_req(1'b1, 64'h40, 64'h5A5A5A5A_5A5A5A5A, 8'h00, 0, 1'b0);
      do_req(1'b0, 64'h40, 64'd0, 8'h00, 0, 1'b0);

      for (int t = 0; t < 200; t++) begin
         sel = $urandom_range(0, 9);
         if (sel <= 6)      a = 64'(8 * $urandom_range(0, 15));
         else if (sel == 7) a = 64'(8 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 7));
         else if (sel == 8) a = 64'(8 * DEPTH + 8 * $urandom_range(0, 15));
         else               a = {$urandom, $urandom};
         do_req(1'($urandom), a, {$urandom, $urandom}, 8'($urandom),
                ($urandom_range(0, 7) == 0) ? 10 : $urandom_range(0, 3),
                1'($urandom));
      end

      repeat (3) @(posedge clk);
      #1;
      check64("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
